// File: rtl/addsub_pipe_if.sv
// Operation/result bundle for addsub_pipe; flag signals exist only when ADDSUB_PIPE_FLAGS_EN is defined.
// Handshake: an item moves across a boundary on a rising clk edge where its valid and ready are both 1;
// a valid producer holds its payload stable until that edge, and ready may depend combinationally on downstream ready.
interface addsub_pipe_if #(
  parameter int WIDTH = 256,
  parameter int TAG_W = 4
);
  logic             valid_in;
  logic             ready_out;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             op_sub;
  logic             cin;
  logic [TAG_W-1:0] tag_in;
  logic             valid_out;
  logic             ready_in;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic [TAG_W-1:0] tag_out;
`ifdef ADDSUB_PIPE_FLAGS_EN
  logic             zero;
  logic             eq_sel;

  modport master (
    output valid_in, a, b, op_sub, cin, tag_in, ready_in,
    input  ready_out, valid_out, s, cout, tag_out, zero, eq_sel
  );
  modport slave (
    input  valid_in, a, b, op_sub, cin, tag_in, ready_in,
    output ready_out, valid_out, s, cout, tag_out, zero, eq_sel
  );
`else
  modport master (
    output valid_in, a, b, op_sub, cin, tag_in, ready_in,
    input  ready_out, valid_out, s, cout, tag_out
  );
  modport slave (
    input  valid_in, a, b, op_sub, cin, tag_in, ready_in,
    output ready_out, valid_out, s, cout, tag_out
  );
`endif
endinterface

// File: rtl/addsub_pipe.sv
// Limb-serial elastic add/subtract pipeline: stage k resolves limb k, the last stage is the output register.
// Optional zero/eq_sel flag outputs are built when ADDSUB_PIPE_FLAGS_EN is defined.
module addsub_pipe #(
  parameter int WIDTH = 256,
  parameter int LIMB  = 64,
  parameter int TAG_W = 4
) (
  input  logic         clk,
  input  logic         reset,
  addsub_pipe_if.slave bus
);
  localparam int NSTG = (WIDTH / LIMB < 1) ? 1 : WIDTH / LIMB;

  logic [NSTG:0]    adv;
  logic [NSTG-1:0]  valid_q, valid_d;
  logic [NSTG-1:0]  sub_q, sub_d;
  logic [NSTG-1:0]  c_q, c_d, cin_d;
  logic [TAG_W-1:0] tag_q [NSTG];
  logic [TAG_W-1:0] tag_d [NSTG];
  logic [WIDTH-1:0] a_q [NSTG];
  logic [WIDTH-1:0] a_d [NSTG];
  logic [WIDTH-1:0] b_q [NSTG];
  logic [WIDTH-1:0] b_d [NSTG];
  logic [WIDTH-1:0] s_q [NSTG];
  logic [WIDTH-1:0] s_d [NSTG];
  logic [LIMB:0]    limb_sum [NSTG];
`ifdef ADDSUB_PIPE_FLAGS_EN
  logic [NSTG-1:0]  z_q, z_d, zin_d;
`endif

  // A stage may load when it is empty or the stage after it is moving.
  always_comb begin
    adv[NSTG] = bus.ready_in;
    for (int k = NSTG - 1; k >= 0; k--) begin
      adv[k] = ~valid_q[k] | adv[k+1];
    end
  end

  always_comb begin
    for (int k = 0; k < NSTG; k++) begin
      int prev;
      prev = (k == 0) ? 0 : k - 1;
      if (k == 0) begin
        valid_d[k] = bus.valid_in;
        sub_d[k]   = bus.op_sub;
        tag_d[k]   = bus.tag_in;
        a_d[k]     = bus.a;
        b_d[k]     = bus.op_sub ? ~bus.b : bus.b;
        // Subtract as a + ~b + ~borrow so every stage uses plain true-carry addition.
        cin_d[k]   = bus.op_sub ^ bus.cin;
        s_d[k]     = '0;
`ifdef ADDSUB_PIPE_FLAGS_EN
        zin_d[k]   = 1'b1;
`endif
      end else begin
        valid_d[k] = valid_q[prev];
        sub_d[k]   = sub_q[prev];
        tag_d[k]   = tag_q[prev];
        a_d[k]     = a_q[prev];
        b_d[k]     = b_q[prev];
        cin_d[k]   = c_q[prev];
        s_d[k]     = s_q[prev];
`ifdef ADDSUB_PIPE_FLAGS_EN
        zin_d[k]   = z_q[prev];
`endif
      end
      limb_sum[k] = {1'b0, a_d[k][k*LIMB +: LIMB]} + {1'b0, b_d[k][k*LIMB +: LIMB]}
                  + {{LIMB{1'b0}}, cin_d[k]};
      s_d[k][k*LIMB +: LIMB] = limb_sum[k][LIMB-1:0];
      c_d[k] = limb_sum[k][LIMB];
`ifdef ADDSUB_PIPE_FLAGS_EN
      z_d[k] = zin_d[k] & (limb_sum[k][LIMB-1:0] == '0);
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      sub_q   <= '0;
      c_q     <= '0;
`ifdef ADDSUB_PIPE_FLAGS_EN
      z_q     <= '0;
`endif
      for (int k = 0; k < NSTG; k++) begin
        tag_q[k] <= '0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        s_q[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < NSTG; k++) begin
        if (adv[k]) begin
          valid_q[k] <= valid_d[k];
          // Bubbles move on but leave the data fields untouched.
          if (valid_d[k]) begin
            sub_q[k] <= sub_d[k];
            tag_q[k] <= tag_d[k];
            a_q[k]   <= a_d[k];
            b_q[k]   <= b_d[k];
            s_q[k]   <= s_d[k];
            c_q[k]   <= c_d[k];
`ifdef ADDSUB_PIPE_FLAGS_EN
            z_q[k]   <= z_d[k];
`endif
          end
        end
      end
    end
  end

  assign bus.ready_out = adv[0];
  assign bus.valid_out = valid_q[NSTG-1];
  assign bus.s         = s_q[NSTG-1];
  assign bus.cout      = sub_q[NSTG-1] ^ c_q[NSTG-1];
  assign bus.tag_out   = tag_q[NSTG-1];
`ifdef ADDSUB_PIPE_FLAGS_EN
  assign bus.zero      = z_q[NSTG-1];
  assign bus.eq_sel    = sub_q[NSTG-1] & z_q[NSTG-1];
`endif
endmodule

// File: tb/tb_addsub_pipe.sv
// Directed bench for addsub_pipe: default 256/64 instance plus NSTG=2 and NSTG=1 instances.
module tb_addsub_pipe;
  localparam int W  = 256;
  localparam int TW = 4;
  localparam int EW = W + TW + 3;
  localparam logic [W-1:0] ONES = {W{1'b1}};

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  addsub_pipe_if #(.WIDTH(W),  .TAG_W(TW)) bus ();
  addsub_pipe_if #(.WIDTH(64), .TAG_W(TW)) bus2 ();
  addsub_pipe_if #(.WIDTH(32), .TAG_W(TW)) bus3 ();

  addsub_pipe #(.WIDTH(W),  .LIMB(64), .TAG_W(TW)) u_dut  (.clk(clk), .reset(reset), .bus(bus));
  addsub_pipe #(.WIDTH(64), .LIMB(32), .TAG_W(TW)) u_dut2 (.clk(clk), .reset(reset), .bus(bus2));
  addsub_pipe #(.WIDTH(32), .LIMB(32), .TAG_W(TW)) u_dut3 (.clk(clk), .reset(reset), .bus(bus3));

  typedef struct packed {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          sub;
    logic          cin;
    logic [TW-1:0] tag;
    logic [W-1:0]  s;
    logic          co;
    logic          z;
  } vec_t;

  vec_t vecs [12];
  logic [EW-1:0] exp_q [$];
  logic [EW-1:0] e;
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int xfer_cyc [$];

  function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                              input logic cin, input logic [TW-1:0] tag, input logic [W-1:0] s,
                              input logic co, input logic z);
    vec_t v;
    v.a = a; v.b = b; v.sub = sub; v.cin = cin; v.tag = tag; v.s = s; v.co = co; v.z = z;
    return v;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%b exp=%b", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_inputs(input int i);
    bus.a      = vecs[i].a;
    bus.b      = vecs[i].b;
    bus.op_sub = vecs[i].sub;
    bus.cin    = vecs[i].cin;
    bus.tag_in = vecs[i].tag;
  endtask

  // Offer vector i; the expected result is queued at the negedge before the accepting edge.
  task automatic send(input int i);
    set_inputs(i);
    bus.valid_in = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus.ready_out) begin
        exp_q.push_back({vecs[i].s, vecs[i].co, vecs[i].tag, vecs[i].z, vecs[i].sub & vecs[i].z});
        @(posedge clk);
        #1;
        bus.valid_in = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    total++;
    bad++;
    $display("FAIL send_timeout vec=%0d", i);
    bus.valid_in = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      tick(1);
      n++;
    end
    chki("drain_empty", exp_q.size(), 0);
  endtask

  // Scoreboard: every output transfer of the main instance must match the oldest expected entry.
  always @(negedge clk) begin
    cyc++;
    if (reset && bus.valid_out && bus.ready_in) begin
      xfer_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out act_tag=%0d exp=none", bus.tag_out);
      end else begin
        e = exp_q.pop_front();
        chk("out_s", bus.s, e[EW-1 -: W]);
        chk1("out_cout", bus.cout, e[TW+2]);
        chki("out_tag", int'(bus.tag_out), int'(e[TW+1:2]));
`ifdef ADDSUB_PIPE_FLAGS_EN
        chk1("out_zero", bus.zero, e[1]);
        chk1("out_eq_sel", bus.eq_sel, e[0]);
`endif
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1);
  end

  initial begin
    vecs[0]  = mk(W'(1), (W'(1) << 64) - W'(1), 1'b0, 1'b0, 4'd3, W'(1) << 64, 1'b0, 1'b0);
    vecs[1]  = mk(ONES, '0, 1'b0, 1'b1, 4'd0, '0, 1'b1, 1'b1);
    vecs[2]  = mk(W'(5), W'(7), 1'b1, 1'b0, 4'd1, ONES - W'(1), 1'b1, 1'b0);
    vecs[3]  = mk(W'(7), W'(7), 1'b1, 1'b0, 4'd2, '0, 1'b0, 1'b1);
    vecs[4]  = mk(W'(1) << 255, W'(1) << 255, 1'b0, 1'b0, 4'd3, '0, 1'b1, 1'b1);
    vecs[5]  = mk('0, '0, 1'b1, 1'b1, 4'd4, ONES, 1'b1, 1'b0);
    vecs[6]  = mk((W'(1) << 128) - W'(1), W'(1), 1'b0, 1'b0, 4'd5, W'(1) << 128, 1'b0, 1'b0);
    vecs[7]  = mk(W'(1) << 192, W'(1), 1'b1, 1'b0, 4'd6, (W'(1) << 192) - W'(1), 1'b0, 1'b0);
    vecs[8]  = mk(W'(16'h1234), W'(16'h0010), 1'b0, 1'b1, 4'd7, W'(16'h1245), 1'b0, 1'b0);
    vecs[9]  = mk(W'(100), W'(50), 1'b1, 1'b1, 4'd8, W'(49), 1'b0, 1'b0);
    vecs[10] = mk(W'(1) << 64, '0, 1'b1, 1'b1, 4'd9, (W'(1) << 64) - W'(1), 1'b0, 1'b0);
    vecs[11] = mk(ONES, ONES, 1'b0, 1'b1, 4'd10, ONES, 1'b1, 1'b0);

    bus.valid_in = 1'b0; bus.ready_in = 1'b1; set_inputs(0);
    bus2.valid_in = 1'b0; bus2.ready_in = 1'b1; bus2.a = '0; bus2.b = '0;
    bus2.op_sub = 1'b0; bus2.cin = 1'b0; bus2.tag_in = '0;
    bus3.valid_in = 1'b0; bus3.ready_in = 1'b1; bus3.a = '0; bus3.b = '0;
    bus3.op_sub = 1'b0; bus3.cin = 1'b0; bus3.tag_in = '0;

    // Reset values
    #2 reset = 1'b0;
    tick(3);
    chk1("rst_valid_out", bus.valid_out, 1'b0);
    chk("rst_s", bus.s, '0);
    chk1("rst_cout", bus.cout, 1'b0);
    chki("rst_tag", int'(bus.tag_out), 0);
    chk1("rst_ready_out", bus.ready_out, 1'b1);
`ifdef ADDSUB_PIPE_FLAGS_EN
    chk1("rst_zero", bus.zero, 1'b0);
    chk1("rst_eq_sel", bus.eq_sel, 1'b0);
`endif
    reset = 1'b1;
    tick(1);

    // Single add: presented 3 cycles after acceptance
    send(0);
    begin
      int n;
      n = 0;
      while (!bus.valid_out && n < 20) begin
        tick(1);
        n++;
      end
      chki("latency_nstg4", n, 3);
    end
    drain();

    // Back-to-back: tags 0..7 on consecutive cycles
    xfer_cyc.delete();
    for (int i = 1; i <= 8; i++) send(i);
    drain();
    chki("b2b_count", xfer_cyc.size(), 8);
    if (xfer_cyc.size() == 8) chki("b2b_gapless", xfer_cyc[7] - xfer_cyc[0], 7);

    // Backpressure: fill while stalled, hold 5 cycles, then drain in order
    xfer_cyc.delete();
    bus.ready_in = 1'b0;
    send(9); send(10); send(11); send(4);
    bus.valid_in = 1'b1;
    for (int j = 0; j < 5; j++) begin
      set_inputs(j + 5);
      tick(1);
      chk1("stall_ready_out", bus.ready_out, 1'b0);
      chk1("stall_valid_out", bus.valid_out, 1'b1);
      chk("stall_s", bus.s, vecs[9].s);
      chk1("stall_cout", bus.cout, vecs[9].co);
      chki("stall_tag", int'(bus.tag_out), int'(vecs[9].tag));
    end
    bus.ready_in = 1'b1;
    send(2);
    drain();
    chki("stall_drain_count", xfer_cyc.size(), 5);

    // NSTG=2 instance: latency 1, hold under stall
    bus2.a = 64'hFFFF_FFFF; bus2.b = 64'd1; bus2.op_sub = 1'b0; bus2.cin = 1'b0;
    bus2.tag_in = 4'd5; bus2.valid_in = 1'b1; bus2.ready_in = 1'b1;
    #1 chk1("n2_ready_out", bus2.ready_out, 1'b1);
    tick(1);
    bus2.valid_in = 1'b0;
    chk1("n2_not_yet", bus2.valid_out, 1'b0);
    tick(1);
    chk1("n2_valid", bus2.valid_out, 1'b1);
    chk("n2_add_s", W'(bus2.s), W'(64'h1_0000_0000));
    chk1("n2_add_cout", bus2.cout, 1'b0);
    chki("n2_add_tag", int'(bus2.tag_out), 5);
    bus2.a = 64'd3; bus2.b = 64'd5; bus2.op_sub = 1'b1; bus2.tag_in = 4'd6; bus2.valid_in = 1'b1;
    tick(1);
    bus2.valid_in = 1'b0;
    bus2.ready_in = 1'b0;
    tick(1);
    chk1("n2_sub_valid", bus2.valid_out, 1'b1);
    chk("n2_sub_s", W'(bus2.s), W'(64'hFFFF_FFFF_FFFF_FFFE));
    chk1("n2_sub_cout", bus2.cout, 1'b1);
    chki("n2_sub_tag", int'(bus2.tag_out), 6);
    tick(2);
    chk1("n2_hold_valid", bus2.valid_out, 1'b1);
    chk("n2_hold_s", W'(bus2.s), W'(64'hFFFF_FFFF_FFFF_FFFE));
    bus2.ready_in = 1'b1;
    tick(1);
    chk1("n2_drained", bus2.valid_out, 1'b0);

    // NSTG=1 instance: result on the accepting edge, ready_out = ~valid_out | ready_in
    bus3.a = 32'hFFFF_FFFF; bus3.b = '0; bus3.op_sub = 1'b0; bus3.cin = 1'b1;
    bus3.tag_in = 4'd9; bus3.valid_in = 1'b1; bus3.ready_in = 1'b0;
    #1 chk1("n1_ready_empty", bus3.ready_out, 1'b1);
    tick(1);
    bus3.valid_in = 1'b0;
    chk1("n1_valid", bus3.valid_out, 1'b1);
    chk("n1_s", W'(bus3.s), '0);
    chk1("n1_cout", bus3.cout, 1'b1);
    chki("n1_tag", int'(bus3.tag_out), 9);
`ifdef ADDSUB_PIPE_FLAGS_EN
    chk1("n1_zero", bus3.zero, 1'b1);
    chk1("n1_eq_sel", bus3.eq_sel, 1'b0);
`endif
    #1 chk1("n1_ready_blocked", bus3.ready_out, 1'b0);
    bus3.ready_in = 1'b1;
    #1 chk1("n1_ready_pass", bus3.ready_out, 1'b1);
    tick(1);
    chk1("n1_drained", bus3.valid_out, 1'b0);

    // Reset with operations in flight in all three instances
    bus2.a = 64'd1; bus2.b = 64'd1; bus2.op_sub = 1'b0; bus2.tag_in = 4'd1;
    bus2.valid_in = 1'b1; bus2.ready_in = 1'b0;
    bus3.a = 32'd5; bus3.b = 32'd6; bus3.cin = 1'b0; bus3.tag_in = 4'd2;
    bus3.valid_in = 1'b1; bus3.ready_in = 1'b0;
    send(3); send(6); send(7);
    bus2.valid_in = 1'b0;
    bus3.valid_in = 1'b0;
    reset = 1'b0;
    #1;
    exp_q.delete();
    chk1("mid_rst_valid_out", bus.valid_out, 1'b0);
    chk("mid_rst_s", bus.s, '0);
    chk1("mid_rst_cout", bus.cout, 1'b0);
    chki("mid_rst_tag", int'(bus.tag_out), 0);
    chk1("mid_rst_n2_valid", bus2.valid_out, 1'b0);
    chk1("mid_rst_n1_valid", bus3.valid_out, 1'b0);
    chk("mid_rst_n1_s", W'(bus3.s), '0);
    tick(2);
    reset = 1'b1;
    bus2.ready_in = 1'b1;
    bus3.ready_in = 1'b1;
    for (int j = 0; j < 10; j++) begin
      tick(1);
      chk1("post_rst_valid", bus.valid_out, 1'b0);
      chk1("post_rst_n2_valid", bus2.valid_out, 1'b0);
      chk1("post_rst_n1_valid", bus3.valid_out, 1'b0);
    end
    send(8);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/addsub_pipe.md
Name: addsub_pipe

Overview:
- Parametrised, limb-serial pipelined add/subtract unit for wide field arithmetic in the ECDSA datapath.
- Next generation of the fixed 256-bit 4-stage adder. Generalises operand width and limb size, and adds a subtract mode, carry/borrow-in and a sideband tag.
- Uses a valid/ready elastic pipeline with one result per cycle at full throughput and correct stall propagation.
- Sits between the operand scheduler and the modular reduction and point-arithmetic units.

Parameters:
- WIDTH, 256: operand and result width in bits. Must be a multiple of LIMB.
- LIMB, 64: bits processed per pipeline stage. NSTG = WIDTH/LIMB stages, minimum 1.
- TAG_W, 4: width of the sideband tag carried alongside each operation.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- valid_in  input  1  upstream offers an operation.
- ready_out  output  1  block can accept an operation this cycle.
- a  input  WIDTH  first operand.
- b  input  WIDTH  second operand.
- op_sub  input  1  0 = a+b+cin; 1 = a-b-cin, where cin is a borrow.
- cin  input  1  carry-in for add, borrow-in for subtract.
- tag_in  input  TAG_W  sideband tag, returned unchanged with the result.
- valid_out  output  1  result available.
- ready_in  input  1  downstream accepts the result.
- s  output  WIDTH  sum or difference, modulo 2^WIDTH.
- cout  output  1  add: carry-out. Sub: borrow-out, 1 iff a < b+cin as unsigned values.
- tag_out  output  TAG_W  tag of the result currently presented.

Behaviour:
- Reset (async assert, sync release): all stage valid bits = 0; valid_out = 0; s = 0; cout = 0; tag_out = 0. Datapath registers reset to 0.
- Stage k (0..NSTG-1) holds the following for one operation:
  - valid_k
  - op_sub, tag
  - carry, in normalised true-carry form
  - result limbs 0..k-1 already computed
  - operand limbs k..NSTG-1 still pending
- Stage 0 captures from the inputs. It computes limb 0 as a[L-1:0] + b'[L-1:0] + c0, where:
  - b' = op_sub ? ~b : b
  - c0 = op_sub ? ~cin : cin
- Stage k computes limb k from its own stored operands and the carry registered by stage k-1.
- The last stage's register is the output register: s, cout and tag_out are driven by it and valid_out = valid_{NSTG-1}.
- For subtract, cout = ~final carry, i.e. the borrow.
- Latency: an operation accepted on edge T has valid_out = 1 after edge T+NSTG-1, i.e. it is presented NSTG-1 cycles after acceptance.
- Handshake:
  - A transfer occurs when valid && ready are both high on a rising edge.
  - Stage k advances, loading from stage k-1 or from the inputs for k=0, when adv_k = ~valid_k | adv_{k+1}, with adv_NSTG = ready_in.
  - ready_out = adv_0. This is combinational from ready_in through the chain; there are no registered ready bubbles.
  - When a stage advances, valid_k <= valid_{k-1} (valid_in for k=0). Data registers load only when the incoming valid is 1. A held stage keeps every field unchanged.
  - With ready_in held 1 and valid_in held 1, throughput is one operation per cycle with no gaps.
- Boundary conditions:
  - Downstream stall (ready_in = 0) with the pipe full: ready_out = 0 and all contents frozen, including s, cout and tag_out. Nothing is lost or duplicated.
  - Stall with the pipe partly full: empty stages still fill (bubbles collapse). ready_out = 1 until stage 0 is occupied and blocked.
  - valid_out is held until accepted. s, cout and tag_out must not change while valid_out = 1 && ready_in = 0.
  - Input changes while ready_out = 0 are ignored.
  - Carry chain across all limbs is exact: a = 2^WIDTH-1, b = 0, cin = 1 gives s = 0, cout = 1.
  - NSTG = 1: a single registered stage, latency 0 cycles after acceptance (registered output), ready_out = ~valid_out | ready_in.
  - Reset mid-operation: all in-flight operations are discarded. No output may be produced for them after reset release.

Optional Feature:
- Macro ADDSUB_PIPE_FLAGS_EN.
- Defined: adds outputs zero (1 bit) and eq_sel (1 bit), registered with the result.
  - zero = 1 iff s == 0.
  - eq_sel = op_sub && zero, marking equality of a and b+cin.
  - Zero is accumulated per limb (AND of per-limb zero) through the stages. No WIDTH-wide compare at the output.
  - Both flags reset to 0, follow the same hold rules as s, and add no latency.
- Undefined: ports and logic are absent. All other behaviour is identical.

Test Plan:
- Default params, single add a=1, b=2^64-1, cin=0, tag=3, ready_in=1 -> valid_out exactly 3 cycles after accept; s=2^64, cout=0, tag_out=3.
- Carry ripple: a=2^256-1, b=0, cin=1, add -> s=0, cout=1. Flags build: zero=1.
- Subtract: op_sub=1, a=5, b=7, cin=0 -> s=2^256-2, cout=1. Then a=7, b=7 -> s=0, cout=0, eq_sel=1 (flags build).
- Back-to-back: 8 consecutive ops with tags 0..7 and ready_in=1 -> results in order on 8 consecutive cycles, each correct, with no bubbles.
- Backpressure: pipe full, ready_in=0 for 5 cycles -> ready_out=0 and output stable. Release -> remaining ops drain in order with correct values and no duplicates.
- Reset while 3 ops are in flight -> all outputs 0 immediately. After release, valid_out stays 0 until new ops are accepted. Repeat with LIMB=32 and WIDTH=64 (NSTG=2, latency 1), and with NSTG=1.
